// File: rtl/apb_mem_completer_if.sv
// APB4 signal bundle between a requester and the memory completer.
interface apb_mem_completer_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32
) ();
   logic                      psel;
   logic                      penable;
   logic                      pwrite;
   logic [ADDR_WIDTH-1:0]     paddr;
   logic [DATA_WIDTH-1:0]     pwdata;
   logic [DATA_WIDTH/8-1:0]   pstrb;
   logic [DATA_WIDTH-1:0]     prdata;
   logic                      pready;
   logic                      pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata, pstrb,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata, pstrb,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/apb_mem_completer.sv
// APB4 completer backed by a word-addressed memory with byte-strobed writes,
// a fixed number of wait states per access and pslverr on illegal accesses.
module apb_mem_completer #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned MEM_DEPTH   = 256,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   apb_mem_completer_if.slave bus
);

   localparam int unsigned            Bytes    = DATA_WIDTH / 8;
   localparam int unsigned            OffBits  = $clog2(Bytes);
   localparam int unsigned            IdxBits  = $clog2(MEM_DEPTH);
   localparam logic [ADDR_WIDTH-1:0]  MemBytes = ADDR_WIDTH'(MEM_DEPTH * Bytes);
   localparam logic [ADDR_WIDTH-1:0]  OffMask  = ADDR_WIDTH'(Bytes - 1);
   localparam logic [3:0]             WaitLoad = 4'(WAIT_STATES);

   typedef enum logic [1:0] {StIdle, StSetupSeen, StWait, StDone} state_e;

   state_e                  state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic                    latch_en;

   logic                    wr_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [Bytes-1:0]        strb_q;

   logic                    pready_q, pready_d;
   logic                    pslverr_q, pslverr_d;
   logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;

   logic                    complete_d;
   logic                    sel_wr;
   logic [ADDR_WIDTH-1:0]   sel_addr;
   logic [Bytes-1:0]        sel_strb;
   logic [IdxBits-1:0]      sel_idx;
   logic                    sel_err;

   logic                    mem_we;
   logic [IdxBits-1:0]      wr_idx;
   logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

   // State, wait counter, setup-phase latches and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         cnt_q     <= 4'd0;
         wr_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         strb_q    <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         prdata_q  <= prdata_d;
         if (latch_en) begin
            wr_q    <= bus.pwrite;
            addr_q  <= bus.paddr;
            wdata_q <= bus.pwdata;
            strb_q  <= bus.pstrb;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      latch_en = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.psel && !bus.penable) begin
               state_d  = StSetupSeen;
               cnt_d    = WaitLoad;
               latch_en = 1'b1;
            end
         end
         StSetupSeen, StWait: begin
            // A zero count in StSetupSeen means this cycle was the completion.
            if (!bus.psel || cnt_q == 4'd0) begin
               state_d = StIdle;
               cnt_d   = 4'd0;
            end else begin
               cnt_d   = cnt_q - 4'd1;
               state_d = (cnt_q == 4'd1) ? StDone : StWait;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // Outputs are registered, so they are computed for the cycle being entered.
   // Entering straight from idle (no wait states) the bus still holds the setup values.
   always_comb begin
      complete_d = (state_d == StDone) || (state_d == StSetupSeen && cnt_d == 4'd0);
      if (state_q == StIdle) begin
         sel_wr   = bus.pwrite;
         sel_addr = bus.paddr;
         sel_strb = bus.pstrb;
      end else begin
         sel_wr   = wr_q;
         sel_addr = addr_q;
         sel_strb = strb_q;
      end
      sel_idx = sel_addr[OffBits +: IdxBits];
      sel_err = (sel_addr >= MemBytes) || ((sel_addr & OffMask) != '0) ||
                (!sel_wr && sel_strb != '0);
      pready_d  = complete_d;
      pslverr_d = complete_d && sel_err;
      prdata_d  = (complete_d && !sel_err && !sel_wr) ? mem[sel_idx] : '0;
   end

   assign wr_idx = addr_q[OffBits +: IdxBits];
   assign mem_we = pready_q && wr_q && !pslverr_q && bus.psel && bus.penable;

   // Contents survive reset; only control state is cleared.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < int'(Bytes); i++) begin
            if (strb_q[i]) mem[wr_idx][8*i +: 8] <= wdata_q[8*i +: 8];
         end
      end
   end

   assign bus.pready  = pready_q;
   assign bus.pslverr = pslverr_q;
   assign bus.prdata  = prdata_q;

endmodule

// File: tb/tb_apb_mem_completer.sv
// Randomised scoreboard bench for apb_mem_completer: one instance with no wait
// states and one with three, driven from a shared requester.
module tb_apb_mem_completer;

   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 32;
   localparam int unsigned DEPTH = 256;
   localparam int unsigned W1    = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        psel, penable, pwrite;
   logic [31:0] paddr, pwdata;
   logic [3:0]  pstrb;
   bit          dut_sel;

   always #5 clk = ~clk;

   apb_mem_completer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
   apb_mem_completer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();

   assign bus0.psel    = psel & ~dut_sel;
   assign bus0.penable = penable;
   assign bus0.pwrite  = pwrite;
   assign bus0.paddr   = paddr;
   assign bus0.pwdata  = pwdata;
   assign bus0.pstrb   = pstrb;
   assign bus1.psel    = psel & dut_sel;
   assign bus1.penable = penable;
   assign bus1.pwrite  = pwrite;
   assign bus1.paddr   = paddr;
   assign bus1.pwdata  = pwdata;
   assign bus1.pstrb   = pstrb;

   apb_mem_completer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH), .WAIT_STATES(0))
      u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   apb_mem_completer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH), .WAIT_STATES(W1))
      u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   typedef struct {
      int          dut;
      bit          wr;
      bit          err;
      logic [31:0] rdata;
      int          done_cyc;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] model [2][DEPTH];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: every completion must match the oldest outstanding expectation.
   always @(negedge clk) begin : mon
      logic        rdy, err;
      logic [31:0] rd;
      exp_t        e;
      if (rst_n === 1'b1) begin
         for (int d = 0; d < 2; d++) begin
            rdy = d ? bus1.pready  : bus0.pready;
            err = d ? bus1.pslverr : bus0.pslverr;
            rd  = d ? bus1.prdata  : bus0.prdata;
            if (rdy === 1'b1) begin
               if (sb.size() == 0 || sb[0].dut != d) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_pready dut%0d: got pready=1 required 0", d);
               end else begin
                  e = sb.pop_front();
                  check($sformatf("latency_dut%0d", d), 32'(cyc), 32'(e.done_cyc));
                  check($sformatf("pslverr_dut%0d", d), {31'b0, err}, {31'b0, e.err});
                  if (!e.wr || e.err) check($sformatf("prdata_dut%0d", d), rd, e.rdata);
               end
            end else begin
               check($sformatf("idle_pslverr_dut%0d", d), {31'b0, err}, 32'd0);
               check($sformatf("idle_prdata_dut%0d", d), rd, 32'd0);
            end
         end
      end
   end

   // One complete transfer; leaves psel high so a following call is back-to-back.
   task automatic apb(input int d, input bit wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb);
      exp_t e;
      bit   err;
      bit   done;
      int   widx;
      dut_sel = (d != 0);
      psel    = 1'b1;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = addr;
      pwdata  = data;
      pstrb   = strb;
      err  = (addr >= 32'(DEPTH * 4)) || (addr % 4 != 0) || (!wr && strb != 4'h0);
      widx = int'(addr / 4) % DEPTH;
      e.dut      = d;
      e.wr       = wr;
      e.err      = err;
      e.rdata    = 32'h0;
      e.done_cyc = cyc + 1 + (d != 0 ? int'(W1) : 0);
      if (!err) begin
         if (wr) begin
            for (int b = 0; b < 4; b++)
               if (strb[b]) model[d][widx][8*b +: 8] = data[8*b +: 8];
         end else begin
            e.rdata = model[d][widx];
         end
      end
      sb.push_back(e);
      @(posedge clk); #1;
      penable = 1'b1;
      paddr   = $urandom;
      pwdata  = $urandom;
      pstrb   = 4'($urandom);
      done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if ((d != 0 ? bus1.pready : bus0.pready) === 1'b1) done = 1'b1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL timeout_dut%0d: got no pready within 40 cycles, required one", d);
         sb.delete();
      end
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      psel    = 1'b0;
      penable = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: got no end of test, required finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [31:0] addr;
      logic [3:0]  strb;
      int          d, mode;
      bit          wr;
      rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; pstrb = '0; dut_sel = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_pready0",  {31'b0, bus0.pready},  32'd0);
      check("rst_pslverr0", {31'b0, bus0.pslverr}, 32'd0);
      check("rst_prdata0",  bus0.prdata,           32'd0);
      check("rst_pready1",  {31'b0, bus1.pready},  32'd0);
      check("rst_pslverr1", {31'b0, bus1.pslverr}, 32'd0);
      check("rst_prdata1",  bus1.prdata,           32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int dd = 0; dd < 2; dd++)
         for (int w = 0; w < int'(DEPTH); w++) apb(dd, 1'b1, 32'(w * 4), $urandom, 4'hF);
      idle(1);

      apb(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
      apb(0, 1'b0, 32'h10, 32'h0, 4'h0);
      idle(1);
      apb(0, 1'b1, 32'h20, 32'h11223344, 4'hF);
      apb(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5);
      apb(0, 1'b0, 32'h20, 32'h0, 4'h0);
      apb(0, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF);
      apb(0, 1'b1, 32'h13, 32'hFFFFFFFF, 4'hF);
      apb(0, 1'b0, 32'h10, 32'h0, 4'h1);
      apb(0, 1'b0, 32'h10, 32'h0, 4'h0);
      apb(0, 1'b1, 32'h04, 32'h5A5A5A5A, 4'hF);
      apb(0, 1'b0, 32'h04, 32'h0, 4'h0);
      idle(2);

      apb(1, 1'b0, 32'h10, 32'h0, 4'h0);
      apb(1, 1'b1, 32'h10, 32'h0BADF00D, 4'hF);
      apb(1, 1'b0, 32'h10, 32'h0, 4'h0);
      idle(1);

      // Reset in the completion cycle of a read: outputs must clear at once.
      dut_sel = 1'b0; psel = 1'b1; penable = 1'b0; pwrite = 1'b0;
      paddr = 32'h10; pstrb = 4'h0;
      @(posedge clk); #1;
      penable = 1'b1;
      #1;
      rst_n = 1'b0;
      #1;
      check("async_rst_pready0", {31'b0, bus0.pready}, 32'd0);
      check("async_rst_prdata0", bus0.prdata, 32'd0);
      psel = 1'b0; penable = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Reset during the wait phase of a write: the write must be lost.
      dut_sel = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
      paddr = 32'h08; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b0; psel = 1'b0; penable = 1'b0;
      #1;
      check("wait_rst_pready1",  {31'b0, bus1.pready},  32'd0);
      check("wait_rst_pslverr1", {31'b0, bus1.pslverr}, 32'd0);
      check("wait_rst_prdata1",  bus1.prdata,           32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      apb(1, 1'b0, 32'h08, 32'h0, 4'h0);
      idle(1);

      // psel dropped mid-access: no completion and no write.
      dut_sel = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
      paddr = 32'h0C; pwdata = 32'h12345678; pstrb = 4'hF;
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #1;
      idle(6);
      apb(1, 1'b0, 32'h0C, 32'h0, 4'h0);
      idle(1);

      repeat (300) begin
         d    = int'($urandom_range(0, 1));
         wr   = 1'($urandom_range(0, 1));
         mode = int'($urandom_range(0, 9));
         if (mode == 0)      addr = 32'(DEPTH * 4) + 32'($urandom_range(0, 4000));
         else if (mode == 1) addr = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
         else                addr = 32'($urandom_range(0, DEPTH - 1) * 4);
         if (wr)                               strb = 4'($urandom);
         else if ($urandom_range(0, 7) == 0)   strb = 4'($urandom_range(1, 15));
         else                                  strb = 4'h0;
         apb(d, wr, addr, $urandom, strb);
         if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
      end
      idle(5);
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
